// File: rtl/flit_pkg.sv
// Shared flit encodings and sink-monitor FSM states.
package flit_pkg;

  localparam int unsigned FLIT_TYPE_W = 2;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    TYPE_NONE = 2'd0,
    TYPE_HEAD = 2'd1,
    TYPE_TAIL = 2'd2,
    TYPE_DATA = 2'd3
  } flit_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } sink_state_e;

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count of a W-bit vector.
module popcount_tree #(
  parameter int unsigned W = 66
) (
  input  logic [W-1:0]             din,
  output logic [$clog2(W+1)-1:0]   cnt
);

  localparam int unsigned OW = $clog2(W + 1);

  // Sum of all set bits; synthesis balances the chain into an adder tree.
  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < W; i++) begin
      cnt = cnt + OW'(din[i]);
    end
  end

endmodule

// File: rtl/flit_sink_monitor.sv
// Receive-side flit sink: framing checker, packet/flit/error counters and
// bus toggle accumulator for energy characterization.
module flit_sink_monitor
  import flit_pkg::*;
#(
  parameter int unsigned DATA_W = 66,
  parameter int unsigned TYPE_W = FLIT_TYPE_W,
  parameter int unsigned VCH_W  = 2,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DATA_W-1:0] idata,
  input  logic              ivalid,
  input  logic [VCH_W-1:0]  ivch,
  input  logic              en,
  input  logic              clear,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  flit_cnt,
  output logic [CNT_W-1:0]  tog_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [LEN_W-1:0]  last_len,
  output logic              err
);

  localparam int unsigned POP_W = $clog2(DATA_W + 1);
  localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  sink_state_e       state, state_nxt;
  logic [LEN_W-1:0]  len, len_nxt, len_inc;
  logic [VCH_W-1:0]  vch, vch_nxt;
  logic [TYPE_W-1:0] ftype;
  logic              err_det, pkt_done;

  logic [DATA_W-1:0] prev_data;
  logic [POP_W-1:0]  pop_q, pop_w;
  logic [SUM_W-1:0]  tog_sum;
  logic [CNT_W-1:0]  tog_nxt;

  assign ftype   = idata[DATA_W-1 -: TYPE_W];
  assign len_inc = (len == '1) ? len : len + LEN_W'(1);
  assign busy    = (state == ST_BODY);

  popcount_tree #(.W(DATA_W)) u_pop (
    .din (idata ^ prev_data),
    .cnt (pop_w)
  );

  // Framing checker: next state, packet length, latched VC and error detect.
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    vch_nxt   = vch;
    err_det   = 1'b0;
    pkt_done  = 1'b0;
    if (ivalid) begin
      unique case (state)
        ST_IDLE: begin
          if (ftype == TYPE_W'(TYPE_HEAD)) begin
            state_nxt = ST_BODY;
            len_nxt   = LEN_W'(1);
            vch_nxt   = ivch;
          end else begin
            err_det = 1'b1;
          end
        end
        ST_BODY: begin
          if (ftype == TYPE_W'(TYPE_HEAD)) begin
            err_det = 1'b1;
            len_nxt = LEN_W'(1);
            vch_nxt = ivch;
          end else if (ftype == TYPE_W'(TYPE_DATA) && ivch == vch) begin
            len_nxt = len_inc;
          end else if (ftype == TYPE_W'(TYPE_TAIL) && ivch == vch) begin
            pkt_done  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            err_det = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Saturating toggle accumulation; sum is widened so a wide pop_q cannot wrap it.
  always_comb begin
    tog_sum = SUM_W'(tog_cnt) + SUM_W'(pop_q);
    tog_nxt = (tog_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : tog_sum[CNT_W-1:0];
  end

  // FSM state, packet length and latched virtual channel.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= ST_IDLE;
      len   <= '0;
      vch   <= '0;
    end else if (clear) begin
      state <= ST_IDLE;
      len   <= '0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
      vch   <= vch_nxt;
    end
  end

  // Error pulse and last packet length run independently of the en window.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      err      <= 1'b0;
      last_len <= '0;
    end else if (clear) begin
      err      <= 1'b0;
      last_len <= '0;
    end else begin
      err <= err_det;
      if (pkt_done) last_len <= len_inc;
    end
  end

  // Bus history and per-cycle toggle count; clear reloads history to avoid spurious toggles.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      prev_data <= '0;
      pop_q     <= '0;
    end else begin
      prev_data <= idata;
      pop_q     <= clear ? '0 : pop_w;
    end
  end

  // Saturating statistics counters, accumulating only inside the en window.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pkt_cnt  <= '0;
      flit_cnt <= '0;
      err_cnt  <= '0;
      tog_cnt  <= '0;
    end else if (clear) begin
      pkt_cnt  <= '0;
      flit_cnt <= '0;
      err_cnt  <= '0;
      tog_cnt  <= '0;
    end else if (en) begin
      if (ivalid && flit_cnt != '1) flit_cnt <= flit_cnt + CNT_W'(1);
      if (pkt_done && pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_W'(1);
      if (err_det && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      tog_cnt <= tog_nxt;
    end
  end

endmodule

// File: tb/tb_flit_sink_monitor.sv
// Directed self-checking bench for flit_sink_monitor.
module tb_flit_sink_monitor;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_HEAD = 2'd1;
  localparam logic [1:0] T_TAIL = 2'd2;
  localparam logic [1:0] T_DATA = 2'd3;

  logic        clk, rst_, ivalid, en, clear;
  logic [65:0] idata;
  logic [1:0]  ivch;

  logic        busy, err;
  logic [31:0] pkt_cnt, flit_cnt, tog_cnt, err_cnt;
  logic [7:0]  last_len;

  logic        busy4, err4;
  logic [3:0]  pkt_cnt4, flit_cnt4, tog_cnt4, err_cnt4;
  logic [7:0]  last_len4;

  int vectors;
  int miscompares;

  flit_sink_monitor dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .en(en), .clear(clear), .busy(busy), .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt),
    .tog_cnt(tog_cnt), .err_cnt(err_cnt), .last_len(last_len), .err(err)
  );

  flit_sink_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .en(en), .clear(clear), .busy(busy4), .pkt_cnt(pkt_cnt4), .flit_cnt(flit_cnt4),
    .tog_cnt(tog_cnt4), .err_cnt(err_cnt4), .last_len(last_len4), .err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] t, input logic [1:0] v, input logic [63:0] p);
    idata  = {t, p};
    ivch   = v;
    ivalid = 1'b1;
    tick();
    ivalid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_ = 1'b0; clear = 1'b0; en = 1'b0; ivalid = 1'b0; ivch = '0; idata = '0;
    #12;
    vectors++;
    if (busy !== 1'b0 || err !== 1'b0 || pkt_cnt !== 32'd0 || flit_cnt !== 32'd0 ||
        tog_cnt !== 32'd0 || err_cnt !== 32'd0 || last_len !== 8'd0) begin
      miscompares++;
      $display("FAIL reset: busy=%0d err=%0d pkt=%0d flit=%0d tog=%0d errc=%0d len=%0d expected all 0",
               busy, err, pkt_cnt, flit_cnt, tog_cnt, err_cnt, last_len);
    end
    rst_ = 1'b1;
    en   = 1'b1;
    tick();
  endtask

  task automatic test_packet();
    int busy_cycles;
    busy_cycles = 0;
    send(T_HEAD, 2'd0, 64'd100);
    if (busy === 1'b1) busy_cycles++;
    for (int i = 0; i < 20; i++) begin
      send(T_DATA, 2'd0, 64'(i));
      if (busy === 1'b1) busy_cycles++;
    end
    send(T_TAIL, 2'd0, 64'd200);
    if (busy === 1'b1) busy_cycles++;
    vectors++;
    if (pkt_cnt !== 32'd1) begin miscompares++; $display("FAIL pkt_basic: pkt_cnt=%0d expected 1", pkt_cnt); end
    vectors++;
    if (flit_cnt !== 32'd22) begin miscompares++; $display("FAIL flit_basic: flit_cnt=%0d expected 22", flit_cnt); end
    vectors++;
    if (last_len !== 8'd22) begin miscompares++; $display("FAIL len_basic: last_len=%0d expected 22", last_len); end
    vectors++;
    if (err_cnt !== 32'd0) begin miscompares++; $display("FAIL err_basic: err_cnt=%0d expected 0", err_cnt); end
    vectors++;
    if (busy_cycles != 21) begin miscompares++; $display("FAIL busy_basic: busy cycles=%0d expected 21", busy_cycles); end
  endtask

  task automatic test_toggle();
    idata = '0;
    do_clear();
    idata = '1;
    tick();
    idata = '0;
    tick();
    vectors++;
    if (tog_cnt !== 32'd66) begin miscompares++; $display("FAIL tog_mid: tog_cnt=%0d expected 66", tog_cnt); end
    tick();
    vectors++;
    if (tog_cnt !== 32'd132) begin miscompares++; $display("FAIL tog_final: tog_cnt=%0d expected 132", tog_cnt); end
    tick();
    vectors++;
    if (tog_cnt !== 32'd132) begin miscompares++; $display("FAIL tog_hold: tog_cnt=%0d expected 132", tog_cnt); end
  endtask

  task automatic test_framing_errors();
    int pulses;
    pulses = 0;
    do_clear();
    send(T_DATA, 2'd0, 64'd1);
    if (err === 1'b1) pulses++;
    send(T_HEAD, 2'd0, 64'd2);
    if (err === 1'b1) pulses++;
    send(T_HEAD, 2'd0, 64'd3);
    if (err === 1'b1) pulses++;
    send(T_TAIL, 2'd0, 64'd4);
    if (err === 1'b1) pulses++;
    tick();
    vectors++;
    if (err_cnt !== 32'd2) begin miscompares++; $display("FAIL frame_errcnt: err_cnt=%0d expected 2", err_cnt); end
    vectors++;
    if (pulses != 2) begin miscompares++; $display("FAIL frame_pulses: err pulses=%0d expected 2", pulses); end
    vectors++;
    if (pkt_cnt !== 32'd1) begin miscompares++; $display("FAIL frame_pkt: pkt_cnt=%0d expected 1", pkt_cnt); end
    vectors++;
    if (last_len !== 8'd2) begin miscompares++; $display("FAIL frame_len: last_len=%0d expected 2", last_len); end
  endtask

  task automatic test_vch_mismatch();
    do_clear();
    send(T_HEAD, 2'd1, 64'd5);
    send(T_DATA, 2'd2, 64'd6);
    vectors++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL vch_err: err=%0d busy=%0d expected 1 1", err, busy);
    end
    send(T_TAIL, 2'd1, 64'd7);
    vectors++;
    if (err_cnt !== 32'd1) begin miscompares++; $display("FAIL vch_errcnt: err_cnt=%0d expected 1", err_cnt); end
    vectors++;
    if (pkt_cnt !== 32'd1) begin miscompares++; $display("FAIL vch_pkt: pkt_cnt=%0d expected 1", pkt_cnt); end
    vectors++;
    if (last_len !== 8'd2) begin miscompares++; $display("FAIL vch_len: last_len=%0d expected 2", last_len); end
  endtask

  task automatic test_clear_and_reset();
    do_clear();
    send(T_HEAD, 2'd0, 64'd8);
    send(T_DATA, 2'd0, 64'd9);
    vectors++;
    if (flit_cnt !== 32'd2 || busy !== 1'b1) begin
      miscompares++; $display("FAIL pre_clear: flit_cnt=%0d busy=%0d expected 2 1", flit_cnt, busy);
    end
    // clear coincides with a sampled DATA flit; clear wins
    clear = 1'b1;
    send(T_DATA, 2'd0, 64'd10);
    clear = 1'b0;
    vectors++;
    if (flit_cnt !== 32'd0 || busy !== 1'b0 || err !== 1'b0 || pkt_cnt !== 32'd0 || tog_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL clear_mid: flit=%0d busy=%0d err=%0d pkt=%0d tog=%0d expected all 0",
               flit_cnt, busy, err, pkt_cnt, tog_cnt);
    end
    send(T_HEAD, 2'd0, 64'd11);
    send(T_DATA, 2'd0, 64'd12);
    #2;
    rst_ = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || flit_cnt !== 32'd0 || err_cnt !== 32'd0 || last_len !== 8'd0) begin
      miscompares++;
      $display("FAIL async_reset: busy=%0d flit=%0d errc=%0d len=%0d expected all 0",
               busy, flit_cnt, err_cnt, last_len);
    end
    rst_ = 1'b1;
    send(T_DATA, 2'd0, 64'd13);
    vectors++;
    if (err !== 1'b1 || err_cnt !== 32'd1) begin
      miscompares++; $display("FAIL post_reset_data: err=%0d err_cnt=%0d expected 1 1", err, err_cnt);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    en = 1'b1;
    for (int i = 0; i < 20; i++) send(T_DATA, 2'd0, 64'(i));
    vectors++;
    if (err_cnt4 !== 4'd15) begin miscompares++; $display("FAIL sat_err4: err_cnt=%0d expected 15", err_cnt4); end
    vectors++;
    if (flit_cnt4 !== 4'd15) begin miscompares++; $display("FAIL sat_flit4: flit_cnt=%0d expected 15", flit_cnt4); end
    vectors++;
    if (err_cnt !== 32'd20) begin miscompares++; $display("FAIL sat_err32: err_cnt=%0d expected 20", err_cnt); end
    en = 1'b0;
    for (int i = 0; i < 5; i++) send(T_DATA, 2'd0, 64'(i + 50));
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL en0_pulse: err=%0d expected 1", err); end
    vectors++;
    if (err_cnt !== 32'd20 || flit_cnt !== 32'd20) begin
      miscompares++; $display("FAIL en0_hold: err_cnt=%0d flit_cnt=%0d expected 20 20", err_cnt, flit_cnt);
    end
    vectors++;
    if (err_cnt4 !== 4'd15) begin miscompares++; $display("FAIL en0_hold4: err_cnt=%0d expected 15", err_cnt4); end
    en = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_packet();
    test_toggle();
    test_framing_errors();
    test_vch_mismatch();
    test_clear_and_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
